// File: rtl/ttes_pkg.sv
// Shared types for the ttes counter sequencer: FSM state encoding and command op codes.
// Used by ttes_count_sched and its testbench.
package ttes_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam logic [1:0] OP_STOP  = 2'b00;
  localparam logic [1:0] OP_START = 2'b01;
  localparam logic [1:0] OP_PAUSE = 2'b10;
  localparam logic [1:0] OP_LOAD  = 2'b11;

endpackage

// File: rtl/ttes_count_sched_if.sv
// Command channel into the counter sequencer: valid/ready handshake carrying op and data.
// Master drives the command; slave (the sequencer) returns cmd_ready.
interface ttes_count_sched_if #(
  parameter int WIDTH = 4
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [WIDTH-1:0] cmd_data;

  modport master (output cmd_valid, output cmd_op, output cmd_data, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_op, input cmd_data, output cmd_ready);
endinterface

// File: rtl/ttes_prescaler.sv
// Tick generator: one-cycle tick every presc+1 enabled cycles; clr restarts the period.
// Latency: tick is combinational from the registered phase counter; no backpressure.
module ttes_prescaler (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       clr,
  input  logic [3:0] presc,
  output logic       tick
);

  logic [3:0] cnt_q, cnt_d;

  assign tick = en && (cnt_q == presc);

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = 4'd0;
    end else if (en) begin
      cnt_d = tick ? 4'd0 : cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= 4'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/ttes_count_sched.sv
// Command-driven one-shot/periodic counter with terminal done pulse; commands take effect next cycle.
// cmd_ready drops for one cycle after each accept; TTES_PRESCALE_EN adds a tick prescaler.
module ttes_count_sched
  import ttes_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int TERM_RST = (1 << WIDTH) - 1
) (
  input  logic                clk,
  input  logic                rst,
  ttes_count_sched_if.slave   cmd,
  input  logic                periodic,
  input  logic [3:0]          presc,
  output logic [WIDTH-1:0]    count,
  output logic                done,
  output logic                busy,
  output logic [1:0]          state
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] term_q, term_d;
  logic             rdy_q, rdy_d;
  logic             accept;
  logic             tick;

  assign accept        = cmd.cmd_valid && rdy_q;
  assign cmd.cmd_ready = rdy_q;
  assign count         = count_q;
  assign state         = state_q;
  assign busy          = (state_q == RUN) || (state_q == HOLD);

`ifdef TTES_PRESCALE_EN
  logic presc_clr;
  // Phase restarts whenever the counter (re)enters RUN, so the first step is a full period away.
  assign presc_clr = accept && (cmd.cmd_op == OP_START) && (state_q != RUN);

  ttes_prescaler u_prescaler (
    .clk   (clk),
    .rst   (rst),
    .en    (state_q == RUN),
    .clr   (presc_clr),
    .presc (presc),
    .tick  (tick)
  );
`else
  logic _unused;
  assign _unused = &{1'b0, presc};
  assign tick    = (state_q == RUN);
`endif

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    term_d  = term_q;
    rdy_d   = !accept;
    done    = 1'b0;
    // An accepted command pre-empts any tick in the same cycle.
    if (accept) begin
      case (cmd.cmd_op)
        OP_LOAD: begin
          term_d  = cmd.cmd_data;
          count_d = '0;
          state_d = IDLE;
        end
        OP_START: begin
          if ((state_q == IDLE) || (state_q == DONE)) begin
            state_d = RUN;
            count_d = '0;
          end else if (state_q == HOLD) begin
            state_d = RUN;
          end
        end
        OP_PAUSE: begin
          if (state_q == RUN) begin
            state_d = HOLD;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end else if (tick && (state_q == RUN)) begin
      if (count_q == term_q) begin
        done = 1'b1;
        if (periodic) begin
          count_d = '0;
        end else begin
          state_d = DONE;
        end
      end else begin
        count_d = count_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      count_q <= '0;
      term_q  <= WIDTH'(TERM_RST);
      rdy_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      term_q  <= term_d;
      rdy_q   <= rdy_d;
    end
  end

endmodule
